// File: rtl/dmem_arbiter_pkg.sv
// Shared encodings and default widths for the data-memory arbiter.
// The FSM encodings and stats width are fixed; the widths are defaults that the top can override.
package dmem_arbiter_pkg;

  localparam int DEF_DATA_W   = 32;
  localparam int DEF_ADDR_W   = 7;
  localparam int DEF_MAX_WAIT = 4;
  localparam int DEF_WAIT_W   = 8;
  localparam int STAT_W       = 16;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PEND = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

endpackage

// File: rtl/dmem_arb_sat_cnt.sv
// Saturating up-counter; q increments by one on each cycle inc=1 and holds at all-ones.
// Latency: q reflects an increment one cycle after inc. No backpressure.
module dmem_arb_sat_cnt
  import dmem_arbiter_pkg::*;
#(
  parameter int WIDTH = STAT_W
) (
  input  logic             clk,
  input  logic             arst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] q
);

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      q <= '0;
    end else if (inc && (q != {WIDTH{1'b1}})) begin
      q <= q + WIDTH'(1);
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares dmem between the core MEM stage (priority) and a one-entry buffered debug port; debug rvalid 2..MAX_WAIT+2 cycles after ack.
// Backpressure: dbg_req is held until dbg_ack; a debug request deferred MAX_WAIT cycles stalls the core for one cycle. Stats need DMEM_ARB_STATS_EN.
module dmem_arbiter
  import dmem_arbiter_pkg::*;
#(
  parameter int DATA_W   = DEF_DATA_W,
  parameter int ADDR_W   = DEF_ADDR_W,
  parameter int MAX_WAIT = DEF_MAX_WAIT,
  parameter int WAIT_W   = DEF_WAIT_W
) (
  input  logic              clk,
  input  logic              arst_n,
  input  logic              core_req,
  input  logic              core_we,
  input  logic [ADDR_W-1:0] core_addr,
  input  logic [DATA_W-1:0] core_wdata,
  output logic [DATA_W-1:0] core_rdata,
  output logic              core_stall,
  input  logic              dbg_req,
  input  logic              dbg_we,
  input  logic [ADDR_W-1:0] dbg_addr,
  input  logic [DATA_W-1:0] dbg_wdata,
  output logic              dbg_ack,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [15:0]       stat_stalls,
  output logic [15:0]       stat_dbg
);

  localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(MAX_WAIT);
  localparam logic [WAIT_W-1:0] WAIT_ONE = WAIT_W'(1);

  arb_state_t        r_state;
  arb_state_t        w_state_nxt;
  logic [WAIT_W-1:0] r_wait_cnt;
  logic [WAIT_W-1:0] w_wait_cnt_nxt;
  logic              r_buf_we;
  logic [ADDR_W-1:0] r_buf_addr;
  logic [DATA_W-1:0] r_buf_wdata;
  logic [DATA_W-1:0] r_dbg_rdata;
  logic              w_capture;
  logic              w_forced;
  logic              w_issue;

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_state    <= ST_IDLE;
      r_wait_cnt <= '0;
    end else begin
      r_state    <= w_state_nxt;
      r_wait_cnt <= w_wait_cnt_nxt;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_wait_cnt_nxt = r_wait_cnt;
    w_capture      = 1'b0;
    w_forced       = 1'b0;
    w_issue        = 1'b0;
    dbg_ack        = 1'b0;
    dbg_rvalid     = 1'b0;
    core_stall     = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        dbg_ack   = dbg_req;
        w_capture = dbg_req;
        if (dbg_req) begin
          w_state_nxt = ST_PEND;
        end
      end
      ST_PEND: begin
        // A forced issue takes the slot even from a busy core, which then replays next cycle.
        w_forced   = (r_wait_cnt == WAIT_MAX);
        core_stall = core_req & w_forced;
        w_issue    = !core_req || w_forced;
        if (w_issue) begin
          w_wait_cnt_nxt = '0;
          w_state_nxt    = ST_RESP;
        end else begin
          w_wait_cnt_nxt = r_wait_cnt + WAIT_ONE;
        end
      end
      ST_RESP: begin
        dbg_rvalid  = 1'b1;
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_buf_we    <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_wdata <= '0;
    end else if (w_capture) begin
      r_buf_we    <= dbg_we;
      r_buf_addr  <= dbg_addr;
      r_buf_wdata <= dbg_wdata;
    end
  end

  always_ff @(posedge clk or negedge arst_n) begin
    if (!arst_n) begin
      r_dbg_rdata <= '0;
    end else if (w_issue) begin
      r_dbg_rdata <= mem_rdata;
    end
  end

  assign mem_we     = w_issue ? r_buf_we    : (core_req & core_we);
  assign mem_addr   = w_issue ? r_buf_addr  : core_addr;
  assign mem_wdata  = w_issue ? r_buf_wdata : core_wdata;
  assign core_rdata = mem_rdata;
  assign dbg_rdata  = r_dbg_rdata;

`ifdef DMEM_ARB_STATS_EN
  dmem_arb_sat_cnt #(.WIDTH(16)) u_stat_stalls (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (core_stall),
    .q      (stat_stalls)
  );

  dmem_arb_sat_cnt #(.WIDTH(16)) u_stat_dbg (
    .clk    (clk),
    .arst_n (arst_n),
    .inc    (w_issue),
    .q      (stat_dbg)
  );
`else
  assign stat_stalls = '0;
  assign stat_dbg    = '0;
`endif

endmodule
